dm_cache_controller: RTL and testbench

//  Sequences a direct-mapped, write-back, write-allocate cache: 128 lines of 64 B, 19-bit tag.

---
 rtl/cache_pkg.sv | 20 ++
 rtl/cache_tag_store.sv | 41 ++++
 rtl/dm_cache_controller.sv | 118 +++++++++++
 tb/tb_dm_cache_controller.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// cache_pkg: geometry, FSM encoding and address field helpers for the direct-mapped cache
package cache_pkg;
   localparam int ADDR_W      = 32;
   localparam int DATA_W      = 32;
   localparam int TAG_BITS    = 19;
   localparam int INDEX_BITS  = 7;
   localparam int OFFSET_BITS = 6;
   localparam int LINE_W      = 8 * 2**OFFSET_BITS;
   localparam int LINES       = 2**INDEX_BITS;
   typedef enum logic [2:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE, RESPOND} state_t;
   function automatic logic [TAG_BITS-1:0] get_tag(input logic [ADDR_W-1:0] a);
      return a[ADDR_W-1 -: TAG_BITS];
   endfunction
   function automatic logic [INDEX_BITS-1:0] get_index(input logic [ADDR_W-1:0] a);
      return a[OFFSET_BITS +: INDEX_BITS];
   endfunction
   function automatic logic [OFFSET_BITS-3:0] get_word(input logic [ADDR_W-1:0] a);
      return a[OFFSET_BITS-1:2];
   endfunction
endpackage

// File: rtl/cache_tag_store.sv
// cache_tag_store: tag/valid/dirty arrays with combinational read and synchronous update
module cache_tag_store
   import cache_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [INDEX_BITS-1:0] idx,
   input  logic [TAG_BITS-1:0]   wr_tag,
   input  logic                  fill_en,
   input  logic                  clean_en,
   input  logic                  dirty_en,
   output logic [TAG_BITS-1:0]   rd_tag,
   output logic                  rd_valid,
   output logic                  rd_dirty
);
   logic [TAG_BITS-1:0] tag_q [LINES];
   logic [LINES-1:0]    valid_q, valid_d, dirty_q, dirty_d;
   assign rd_tag   = tag_q[idx];
   assign rd_valid = valid_q[idx];
   assign rd_dirty = dirty_q[idx];
   always_comb begin
      valid_d = valid_q;
      dirty_d = dirty_q;
      if (fill_en) begin
         valid_d[idx] = 1'b1;
         dirty_d[idx] = 1'b0;
      end
      if (clean_en) dirty_d[idx] = 1'b0;
      if (dirty_en) dirty_d[idx] = 1'b1;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else begin
         valid_q <= valid_d;
         dirty_q <= dirty_d;
      end
      if (fill_en) tag_q[idx] <= wr_tag;
   end
endmodule

// File: rtl/dm_cache_controller.sv
// dm_cache_controller: direct-mapped write-back/write-allocate cache sequencer with line data array
module dm_cache_controller
   import cache_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                cpu_req_valid,
   output logic                cpu_req_ready,
   input  logic [ADDR_W-1:0]   cpu_req_addr,
   input  logic                cpu_req_we,
   input  logic [3:0]          cpu_req_wstrb,
   input  logic [DATA_W-1:0]   cpu_req_wdata,
   output logic                cpu_resp_valid,
   output logic [DATA_W-1:0]   cpu_resp_rdata,
   output logic                mem_req,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [LINE_W-1:0]   mem_wdata,
   input  logic [LINE_W-1:0]   mem_rdata,
   input  logic                mem_ready
);
   state_t                 state_q, state_d;
   logic [ADDR_W-1:0]      addr_q, addr_d;
   logic                   we_q, we_d;
   logic [3:0]             wstrb_q, wstrb_d;
   logic [DATA_W-1:0]      wdata_q, wdata_d;
   logic [LINE_W-1:0]      data_q [LINES];
   logic [LINE_W-1:0]      line, line_d;
   logic [INDEX_BITS-1:0]  idx;
   logic [OFFSET_BITS-3:0] word;
   logic [TAG_BITS-1:0]    rd_tag;
   logic                   rd_valid, rd_dirty, hit, fill_en, clean_en, dirty_en;
   assign idx  = get_index(addr_q);
   assign word = get_word(addr_q);
   assign line = data_q[idx];
   assign hit  = rd_valid && rd_tag == get_tag(addr_q);
   cache_tag_store u_tags (
      .clk      (clk),
      .rst      (rst),
      .idx      (idx),
      .wr_tag   (get_tag(addr_q)),
      .fill_en  (fill_en),
      .clean_en (clean_en),
      .dirty_en (dirty_en),
      .rd_tag   (rd_tag),
      .rd_valid (rd_valid),
      .rd_dirty (rd_dirty)
   );
   // Everything stays at its zero default while rst is high, so an abandoned transfer drops at once.
   always_comb begin
      state_d        = state_q;
      addr_d         = addr_q;
      we_d           = we_q;
      wstrb_d        = wstrb_q;
      wdata_d        = wdata_q;
      cpu_req_ready  = 1'b0;
      cpu_resp_valid = 1'b0;
      cpu_resp_rdata = '0;
      mem_req        = 1'b0;
      mem_we         = 1'b0;
      mem_addr       = '0;
      mem_wdata      = '0;
      fill_en        = 1'b0;
      clean_en       = 1'b0;
      dirty_en       = 1'b0;
      if (!rst) begin
         case (state_q)
            IDLE: begin
               cpu_req_ready = 1'b1;
               if (cpu_req_valid) begin
                  addr_d  = cpu_req_addr;
                  we_d    = cpu_req_we;
                  wstrb_d = cpu_req_wstrb;
                  wdata_d = cpu_req_wdata;
                  state_d = COMPARE;
               end
            end
            COMPARE: state_d = hit ? RESPOND : rd_dirty ? WRITEBACK : ALLOCATE;
            WRITEBACK: begin
               mem_req   = 1'b1;
               mem_we    = 1'b1;
               mem_addr  = {rd_tag, idx, {OFFSET_BITS{1'b0}}};
               mem_wdata = line;
               clean_en  = mem_ready;
               state_d   = mem_ready ? ALLOCATE : WRITEBACK;
            end
            ALLOCATE: begin
               mem_req  = 1'b1;
               mem_addr = {get_tag(addr_q), idx, {OFFSET_BITS{1'b0}}};
               fill_en  = mem_ready;
               state_d  = mem_ready ? COMPARE : ALLOCATE;
            end
            RESPOND: begin
               cpu_resp_valid = 1'b1;
               cpu_resp_rdata = we_q ? '0 : line[{word, 5'b0} +: DATA_W];
               dirty_en       = we_q;
               state_d        = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end
   always_comb begin
      line_d = line;
      for (int b = 0; b < 4; b++)
         if (wstrb_q[b]) line_d[{word, b[1:0], 3'b000} +: 8] = wdata_q[8*b +: 8];
      if (fill_en) line_d = mem_rdata;
   end
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wstrb_q <= wstrb_d;
      wdata_q <= wdata_d;
      if (fill_en || dirty_en) data_q[idx] <= line_d;
   end
endmodule

// File: tb/tb_dm_cache_controller.sv
// tb_dm_cache_controller: scoreboard bench with a word-level reference memory and a line memory model
module tb_dm_cache_controller;
   logic         clk = 0;
   logic         rst = 1;
   logic         cpu_req_valid = 0;
   logic         cpu_req_ready;
   logic [31:0]  cpu_req_addr = 0;
   logic         cpu_req_we = 0;
   logic [3:0]   cpu_req_wstrb = 0;
   logic [31:0]  cpu_req_wdata = 0;
   logic         cpu_resp_valid;
   logic [31:0]  cpu_resp_rdata;
   logic         mem_req, mem_we;
   logic [31:0]  mem_addr;
   logic [511:0] mem_wdata;
   logic [511:0] mem_rdata = 0;
   logic         mem_ready = 0;
   typedef struct {logic [31:0] rdata; int lat;} resp_t;
   typedef struct {logic we; logic [31:0] addr; logic [511:0] wdata;} xfer_t;
   resp_t        resp_q[$];
   xfer_t        mem_q[$];
   int           acc_q[$];
   logic [31:0]  shadow [logic [31:0]];
   logic [511:0] mem_lines [logic [31:0]];
   int           compared = 0, mismatched = 0, cyc = 0;
   dm_cache_controller dut (
      .clk(clk), .rst(rst),
      .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
      .cpu_req_addr(cpu_req_addr), .cpu_req_we(cpu_req_we),
      .cpu_req_wstrb(cpu_req_wstrb), .cpu_req_wdata(cpu_req_wdata),
      .cpu_resp_valid(cpu_resp_valid), .cpu_resp_rdata(cpu_resp_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   function automatic logic [31:0] pat(input logic [31:0] a);
      return {a[15:0] ^ 16'hC3A5, a[15:0]};
   endfunction
   function automatic logic [31:0] model_word(input logic [31:0] a);
      return shadow.exists(a) ? shadow[a] : pat(a);
   endfunction
   function automatic logic [511:0] exp_line(input logic [31:0] base);
      logic [511:0] l;
      for (int w = 0; w < 16; w++) l[32*w +: 32] = model_word(base + 32'(4*w));
      return l;
   endfunction
   function automatic logic [511:0] mem_line(input logic [31:0] base);
      logic [511:0] l;
      if (mem_lines.exists(base)) return mem_lines[base];
      for (int w = 0; w < 16; w++) l[32*w +: 32] = pat(base + 32'(4*w));
      return l;
   endfunction
   task automatic expect_xfer(input logic we, input logic [31:0] a, input logic [511:0] wd);
      xfer_t x;
      x.we = we; x.addr = a; x.wdata = wd;
      mem_q.push_back(x);
   endtask
   // One CPU request; the bench also plays memory, answering each transfer after lat idle cycles.
   task automatic cpu_op(input logic we, input logic [31:0] a, input logic [3:0] ws,
                         input logic [31:0] wd, input int xfers, input int lat);
      resp_t e, r;
      xfer_t x;
      logic [31:0] w, wa;
      int n, wcnt;
      logic done;
      wa = {a[31:2], 2'b00};
      e.rdata = we ? 32'h0 : model_word(wa);
      e.lat = xfers == 0 ? 2 : 2 + xfers * (lat + 1) + 1;
      resp_q.push_back(e);
      if (we) begin
         w = model_word(wa);
         for (int b = 0; b < 4; b++) if (ws[b]) w[8*b +: 8] = wd[8*b +: 8];
         shadow[wa] = w;
      end
      @(negedge clk);
      compared++;
      if (cpu_req_ready !== 1'b1) begin
         mismatched++;
         $display("FAIL ready_before_req addr=%h got %b want 1", a, cpu_req_ready);
      end
      cpu_req_valid = 1; cpu_req_addr = a; cpu_req_we = we; cpu_req_wstrb = ws; cpu_req_wdata = wd;
      @(posedge clk);
      @(negedge clk);
      acc_q.push_back(cyc);
      cpu_req_valid = 0;
      n = 1; wcnt = 0; done = 0;
      while (!done && n < 200) begin
         mem_ready = 0;
         if (cpu_resp_valid === 1'b1) begin
            r = resp_q.pop_front();
            compared++;
            if (cpu_resp_rdata !== r.rdata || n != r.lat) begin
               mismatched++;
               $display("FAIL resp addr=%h got data=%h lat=%0d want data=%h lat=%0d",
                        a, cpu_resp_rdata, n, r.rdata, r.lat);
            end
            done = 1;
         end
         if (mem_req === 1'b1) begin
            if (wcnt == lat) begin
               compared++;
               if (mem_q.size() == 0) begin
                  mismatched++;
                  $display("FAIL unexpected_mem_req got we=%b addr=%h want none", mem_we, mem_addr);
               end else begin
                  x = mem_q.pop_front();
                  if (mem_we !== x.we || mem_addr !== x.addr || (x.we && mem_wdata !== x.wdata)) begin
                     mismatched++;
                     $display("FAIL mem_xfer got we=%b addr=%h wdata=%h want we=%b addr=%h wdata=%h",
                              mem_we, mem_addr, mem_wdata, x.we, x.addr, x.wdata);
                  end
               end
               if (mem_we === 1'b1) mem_lines[mem_addr] = mem_wdata;
               mem_rdata = mem_line(mem_addr);
               mem_ready = 1;
               wcnt = 0;
            end else wcnt++;
         end
         if (!done) begin
            @(negedge clk);
            n++;
         end
      end
      mem_ready = 0;
      if (!done) begin
         mismatched++;
         $display("FAIL resp_timeout addr=%h got no response in %0d cycles want one", a, n);
         void'(resp_q.pop_front());
      end
      compared++;
      if (mem_q.size() != 0) begin
         mismatched++;
         $display("FAIL missing_mem_xfer addr=%h got %0d left want 0", a, mem_q.size());
         mem_q.delete();
      end
   endtask
   task automatic test_reset;
      rst = 1;
      repeat (2) @(negedge clk);
      compared++;
      if ({cpu_req_ready, cpu_resp_valid, mem_req, mem_we} !== 4'b0 || mem_addr !== 0 || cpu_resp_rdata !== 0) begin
         mismatched++;
         $display("FAIL reset_outputs got ready=%b resp=%b req=%b we=%b addr=%h want all 0",
                  cpu_req_ready, cpu_resp_valid, mem_req, mem_we, mem_addr);
      end
      rst = 0;
      @(negedge clk);
      compared++;
      if (cpu_req_ready !== 1'b1 || mem_req !== 1'b0) begin
         mismatched++;
         $display("FAIL idle_after_reset got ready=%b req=%b want 1 0", cpu_req_ready, mem_req);
      end
   endtask
   task automatic test_clean_miss;
      expect_xfer(0, 32'h1040, '0);
      cpu_op(0, 32'h1040, 4'h0, 0, 1, 3);
   endtask
   task automatic test_hit;
      cpu_op(0, 32'h1044, 4'h0, 0, 0, 0);
   endtask
   task automatic test_store_merge;
      cpu_op(1, 32'h1048, 4'b0011, 32'hDEADBEEF, 0, 0);
      cpu_op(0, 32'h1048, 4'h0, 0, 0, 0);
      compared++;
      if (model_word(32'h1048) !== {pat(32'h1048) >> 16, 16'hBEEF}) begin
         mismatched++;
         $display("FAIL model_merge got %h want %h", model_word(32'h1048), {pat(32'h1048) >> 16, 16'hBEEF});
      end
   endtask
   task automatic test_dirty_miss;
      expect_xfer(1, 32'h1040, exp_line(32'h1040));
      expect_xfer(0, 32'h3040, '0);
      cpu_op(0, 32'h3048, 4'h0, 0, 2, 1);
   endtask
   task automatic test_reset_mid_op;
      int k;
      expect_xfer(0, 32'h0080, '0);
      cpu_op(0, 32'h0080, 4'h0, 0, 1, 0);
      @(negedge clk);
      cpu_req_valid = 1; cpu_req_addr = 32'h1040; cpu_req_we = 0;
      @(posedge clk);
      @(negedge clk);
      cpu_req_valid = 0;
      k = 0;
      while (mem_req !== 1'b1 && k < 20) begin
         @(negedge clk);
         k++;
      end
      compared++;
      if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h1040) begin
         mismatched++;
         $display("FAIL allocate_before_rst got req=%b we=%b addr=%h want 1 0 00001040", mem_req, mem_we, mem_addr);
      end
      rst = 1;
      @(posedge clk);
      @(negedge clk);
      rst = 0;
      compared++;
      if (mem_req !== 1'b0 || cpu_resp_valid !== 1'b0) begin
         mismatched++;
         $display("FAIL rst_abandon got req=%b resp=%b want 0 0", mem_req, cpu_resp_valid);
      end
      @(negedge clk);
      mem_rdata = mem_line(32'h1040);
      mem_ready = 1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         mem_ready = 0;
         compared++;
         if (mem_req !== 1'b0 || cpu_resp_valid !== 1'b0 || cpu_req_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL stale_ready got req=%b resp=%b ready=%b want 0 0 1", mem_req, cpu_resp_valid, cpu_req_ready);
         end
      end
      expect_xfer(0, 32'h1040, '0);
      cpu_op(0, 32'h1040, 4'h0, 0, 1, 0);
      expect_xfer(0, 32'h0080, '0);
      cpu_op(0, 32'h0084, 4'h0, 0, 1, 2);
   endtask
   task automatic test_back_to_back;
      int a0, a1, a2;
      acc_q.delete();
      cpu_op(0, 32'h1040, 4'h0, 0, 0, 0);
      cpu_op(0, 32'h107C, 4'h0, 0, 0, 0);
      cpu_op(0, 32'h1048, 4'h0, 0, 0, 0);
      a0 = acc_q.pop_front(); a1 = acc_q.pop_front(); a2 = acc_q.pop_front();
      compared++;
      if (a1 - a0 != 3 || a2 - a1 != 3) begin
         mismatched++;
         $display("FAIL b2b_spacing got %0d %0d want 3 3", a1 - a0, a2 - a1);
      end
   endtask
   initial begin
      test_reset;
      test_clean_miss;
      test_hit;
      test_store_merge;
      test_dirty_miss;
      test_reset_mid_op;
      test_back_to_back;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
